// File: rtl/cpu_sequencer.sv
// cpu_sequencer: control FSM for the 8-bit accumulator CPU.
// Sequences fetch / decode / execute over the shared sysbus, stretches
// memory phases while mem_ready is low, halts on HALT until run, and
// counts retired instructions.
module cpu_sequencer #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             z_flag,
  input  logic             mem_ready,
  input  logic             run,
  output logic             ACC_bus,
  output logic             load_ACC,
  output logic             PC_bus,
  output logic             load_PC,
  output logic             INC_PC,
  output logic             load_IR,
  output logic             Addr_bus,
  output logic             load_MAR,
  output logic             MDR_bus,
  output logic             load_MDR,
  output logic             ALU_ACC,
  output logic             ALU_add,
  output logic             ALU_sub,
  output logic             ALU_xor,
  output logic             CS,
  output logic             R_NW,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  // The instruction word must leave room for an address field.
  if (WORD_W <= OP_W) begin : g_bad_width
    $error("cpu_sequencer: WORD_W must exceed OP_W");
  end

  // Opcode encodings shared with the instruction decoder / assembler.
  localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_STORE = OP_W'(1);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_HALT  = OP_W'(6);

  typedef enum logic [2:0] {
    FETCH_A, FETCH_B, EXEC_A, EXEC_B, EXEC_C, HALTED
  } state_t;

  state_t           state, nxt;
  logic             retire;
  logic [CNT_W-1:0] cnt;

  // Opcodes that need a memory operand (address goes to MAR in EXEC_A).
  logic is_mem, is_read_alu;
  assign is_read_alu = (op == OP_LOAD) || (op == OP_ADD) ||
                       (op == OP_SUB)  || (op == OP_XOR);
  assign is_mem      = is_read_alu || (op == OP_STORE);

  // State register and retired-instruction counter; reset abandons the
  // current instruction without counting it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH_A;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (retire) cnt <= cnt + 1'b1;
    end
  end

  // Next-state and strobe decode; Mealy terms depend only on op, z_flag
  // and mem_ready. Reset overrides everything to an idle, non-driving bus.
  always_comb begin
    nxt      = state;
    retire   = 1'b0;
    ACC_bus  = 1'b0;
    load_ACC = 1'b0;
    PC_bus   = 1'b0;
    load_PC  = 1'b0;
    INC_PC   = 1'b0;
    load_IR  = 1'b0;
    Addr_bus = 1'b0;
    load_MAR = 1'b0;
    MDR_bus  = 1'b0;
    load_MDR = 1'b0;
    ALU_ACC  = 1'b0;
    ALU_add  = 1'b0;
    ALU_sub  = 1'b0;
    ALU_xor  = 1'b0;
    CS       = 1'b0;
    R_NW     = 1'b1;
    halted   = 1'b0;

    case (state)
      FETCH_A: begin
        PC_bus   = 1'b1;
        load_MAR = 1'b1;
        nxt      = FETCH_B;
      end

      FETCH_B: begin
        CS      = 1'b1;
        MDR_bus = 1'b1;
        if (mem_ready) begin
          load_IR = 1'b1;
          INC_PC  = 1'b1;
          nxt     = EXEC_A;
        end
      end

      EXEC_A: begin
        if (is_mem) begin
          Addr_bus = 1'b1;
          load_MAR = 1'b1;
          nxt      = EXEC_B;
        end else if (op == OP_BNE) begin
          // Branch target comes straight off the IR address field.
          Addr_bus = !z_flag;
          load_PC  = !z_flag;
          retire   = 1'b1;
          nxt      = FETCH_A;
        end else if (op == OP_HALT) begin
          retire = 1'b1;
          nxt    = HALTED;
        end else begin
          // Unassigned opcode behaves as a NOP.
          retire = 1'b1;
          nxt    = FETCH_A;
        end
      end

      EXEC_B: begin
        if (op == OP_STORE) begin
          ACC_bus  = 1'b1;
          load_MDR = 1'b1;
          nxt      = EXEC_C;
        end else if (is_read_alu) begin
          CS       = 1'b1;
          MDR_bus  = 1'b1;
          ALU_ACC  = 1'b1;
          ALU_add  = (op == OP_ADD);
          ALU_sub  = (op == OP_SUB);
          ALU_xor  = (op == OP_XOR);
          if (mem_ready) begin
            load_ACC = 1'b1;
            retire   = 1'b1;
            nxt      = FETCH_A;
          end
        end else begin
          // IR changed under us: drop back to fetch without retiring.
          nxt = FETCH_A;
        end
      end

      EXEC_C: begin
        CS   = 1'b1;
        R_NW = 1'b0;
        if (mem_ready) begin
          retire = 1'b1;
          nxt    = FETCH_A;
        end
      end

      HALTED: begin
        halted = 1'b1;
        if (run) nxt = FETCH_A;
      end

      default: nxt = FETCH_A;
    endcase

    if (reset) begin
      ACC_bus  = 1'b0;
      load_ACC = 1'b0;
      PC_bus   = 1'b0;
      load_PC  = 1'b0;
      INC_PC   = 1'b0;
      load_IR  = 1'b0;
      Addr_bus = 1'b0;
      load_MAR = 1'b0;
      MDR_bus  = 1'b0;
      load_MDR = 1'b0;
      ALU_ACC  = 1'b0;
      ALU_add  = 1'b0;
      ALU_sub  = 1'b0;
      ALU_xor  = 1'b0;
      CS       = 1'b0;
      R_NW     = 1'b1;
      halted   = 1'b0;
    end
  end

  assign instr_count = reset ? '0 : cnt;

  // Only one driver may own sysbus in any cycle.
  a_bus_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0({ACC_bus, PC_bus, Addr_bus, MDR_bus}));

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized scoreboard bench for cpu_sequencer: a per-instruction trace
// model expands each instruction into its expected per-cycle strobes.
module tb_cpu_sequencer;
  localparam int CNT_W = 4;

  // Same opcode map as the decoder.
  localparam int LOAD = 0, STORE = 1, ADD = 2, SUB = 3, XOR = 4, BNE = 5, HALT = 6, NOP = 7;

  // Output vector bit positions.
  localparam logic [16:0] ACCB = 17'h1 << 16, LACC = 17'h1 << 15, PCB  = 17'h1 << 14,
                          LPC  = 17'h1 << 13, INC  = 17'h1 << 12, LIR  = 17'h1 << 11,
                          ADRB = 17'h1 << 10, LMAR = 17'h1 << 9,  MDRB = 17'h1 << 8,
                          LMDR = 17'h1 << 7,  AACC = 17'h1 << 6,  AADD = 17'h1 << 5,
                          ASUB = 17'h1 << 4,  AXOR = 17'h1 << 3,  CSB  = 17'h1 << 2,
                          RNW  = 17'h1 << 1,  HLT  = 17'h1;

  logic clock, reset, z_flag, mem_ready, run;
  logic [2:0] op;
  logic ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR;
  logic MDR_bus, load_MDR, ALU_ACC, ALU_add, ALU_sub, ALU_xor, CS, R_NW, halted;
  logic [CNT_W-1:0] instr_count;

  cpu_sequencer #(.WORD_W(8), .OP_W(3), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .op(op), .z_flag(z_flag), .mem_ready(mem_ready),
    .run(run), .ACC_bus(ACC_bus), .load_ACC(load_ACC), .PC_bus(PC_bus),
    .load_PC(load_PC), .INC_PC(INC_PC), .load_IR(load_IR), .Addr_bus(Addr_bus),
    .load_MAR(load_MAR), .MDR_bus(MDR_bus), .load_MDR(load_MDR), .ALU_ACC(ALU_ACC),
    .ALU_add(ALU_add), .ALU_sub(ALU_sub), .ALU_xor(ALU_xor), .CS(CS), .R_NW(R_NW),
    .halted(halted), .instr_count(instr_count)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  typedef struct {
    logic rst, mr, rn, z;
    logic [2:0] op;
    logic [16:0] outs;
    logic [CNT_W-1:0] cnt;
    string tag;
  } cyc_t;

  cyc_t stim_q[$];
  cyc_t exp_q[$];
  cyc_t tr[$];
  int   c;            // model retired count (mod 2^CNT_W)
  int   checks, errors, cyc;
  bit   mon_en;
  string cur_tag;
  int   cur_op;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic mr, input logic rn, input logic z, input logic [16:0] outs);
    cyc_t e;
    e.rst = 1'b0; e.mr = mr; e.rn = rn; e.z = z; e.op = 3'(cur_op);
    e.outs = outs; e.cnt = CNT_W'(c); e.tag = cur_tag;
    tr.push_back(e);
  endtask

  task automatic retire();
    c = (c + 1) % (1 << CNT_W);
  endtask

  task automatic push_reset(input string tag);
    cyc_t e;
    e.rst = 1'b1; e.mr = rb(); e.rn = rb(); e.z = rb(); e.op = 3'($urandom_range(0, 7));
    e.outs = RNW; e.cnt = '0; e.tag = tag;
    stim_q.push_back(e); exp_q.push_back(e);
    c = 0;
  endtask

  // Expand one instruction into its cycle trace. wf/wx = wait cycles in the
  // fetch and execute memory phases, hk = halted cycles with run low,
  // cut >= 0 replaces that cycle with a reset (-2 picks one at random).
  task automatic gen(input int opc, input logic z, input int wf, input int wx,
                     input int hk, input int cut, input string tag);
    logic [16:0] fn;
    int k;
    tr.delete();
    cur_op = opc; cur_tag = tag;
    add(rb(), rb(), rb(), PCB | LMAR | RNW);
    for (int i = 0; i < wf; i++) add(1'b0, rb(), rb(), CSB | RNW | MDRB);
    add(1'b1, rb(), rb(), CSB | RNW | MDRB | LIR | INC);
    case (opc)
      LOAD, ADD, SUB, XOR: begin
        fn = AACC | (opc == ADD ? AADD : 17'h0) | (opc == SUB ? ASUB : 17'h0) |
             (opc == XOR ? AXOR : 17'h0);
        add(rb(), rb(), rb(), ADRB | LMAR | RNW);
        for (int i = 0; i < wx; i++) add(1'b0, rb(), rb(), CSB | RNW | MDRB | fn);
        add(1'b1, rb(), rb(), CSB | RNW | MDRB | fn | LACC);
      end
      STORE: begin
        add(rb(), rb(), rb(), ADRB | LMAR | RNW);
        add(rb(), rb(), rb(), ACCB | LMDR | RNW);
        for (int i = 0; i < wx; i++) add(1'b0, rb(), rb(), CSB);
        add(1'b1, rb(), rb(), CSB);
      end
      BNE:     add(rb(), rb(), z, RNW | (z ? 17'h0 : (ADRB | LPC)));
      HALT:    add(rb(), rb(), rb(), RNW);
      default: add(rb(), rb(), rb(), RNW);
    endcase
    if (opc != HALT && cut != -1) begin
      k = (cut == -2) ? int'($urandom_range(0, tr.size() - 1)) : cut;
      while (tr.size() > k) void'(tr.pop_back());
      foreach (tr[i]) begin stim_q.push_back(tr[i]); exp_q.push_back(tr[i]); end
      push_reset({tag, "_rst"});
      return;
    end
    retire();
    if (opc == HALT) begin
      for (int i = 0; i < hk; i++) add(rb(), 1'b0, rb(), HLT | RNW);
      add(rb(), 1'b1, rb(), HLT | RNW);
    end
    foreach (tr[i]) begin stim_q.push_back(tr[i]); exp_q.push_back(tr[i]); end
  endtask

  // Monitor: every cycle the DUT presents a strobe vector; pop and compare.
  always @(negedge clock) begin
    logic [16:0] act;
    cyc_t e;
    if (mon_en) begin
      act = {ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR, Addr_bus, load_MAR,
             MDR_bus, load_MDR, ALU_ACC, ALU_add, ALU_sub, ALU_xor, CS, R_NW, halted};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cycle %0d: got %h, no expected entry", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e.outs) begin
          errors++;
          $display("FAIL strobes[%s] cycle %0d: got %h expected %h", e.tag, cyc, act, e.outs);
        end
        checks++;
        if (instr_count !== e.cnt) begin
          errors++;
          $display("FAIL instr_count[%s] cycle %0d: got %0d expected %0d",
                   e.tag, cyc, instr_count, e.cnt);
        end
        checks++;
        if ($countones({act[16], act[14], act[10], act[8]}) > 1) begin
          errors++;
          $display("FAIL bus_exclusive[%s] cycle %0d: got %h expected at most one bus enable",
                   e.tag, cyc, act);
        end
      end
      cyc++;
    end
  end

  // Stimulus: build the program, then drive one entry per cycle.
  initial begin
    cyc_t s;
    int o;
    checks = 0; errors = 0; cyc = 0; mon_en = 1'b0; c = 0;
    reset = 1'b1; op = '0; z_flag = 1'b0; mem_ready = 1'b0; run = 1'b0;

    push_reset("init"); push_reset("init");
    gen(LOAD,  1'b0, 0, 0, 0, -1, "load");
    gen(STORE, 1'b0, 0, 2, 0, -1, "store_wait2");
    gen(BNE,   1'b0, 0, 0, 0, -1, "bne_taken");
    gen(BNE,   1'b1, 0, 0, 0, -1, "bne_not_taken");
    gen(HALT,  1'b0, 0, 0, 10, -1, "halt10");
    gen(ADD,   1'b0, 0, 2, 0, 3, "add_reset_in_wait");
    for (int i = 0; i < 16; i++) gen(NOP, 1'b0, 0, 0, 0, -1, "nop_wrap");
    gen(HALT,  1'b0, 1, 0, 0, -1, "halt_run_held");
    for (int i = 0; i < 300; i++) begin
      o = $urandom_range(0, 7);
      gen(o, rb(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 19) == 0) ? -2 : -1, "rand");
    end

    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; mem_ready = s.mr; run = s.rn; z_flag = s.z; op = s.op;
      mon_en = 1'b1;
      @(posedge clock);
      #1;
    end
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
